// File: rtl/ternary_neuron_accum.sv
`default_nettype none
// ============================================================================
// Module   : ternary_neuron_accum
// Purpose  : Sequential ternary-weight neuron. Each accepted beat multiplies
//            N_SYN binary activations by registered ternary weights
//            (+1/0/-1), adds the partial sum into a saturating signed
//            accumulator, and on the last beat of a vector presents the
//            final sum, a threshold-fire bit and a sticky saturation flag
//            over a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (weights return to zero)
//   w_load   in   weight write strobe, applied at the next edge in any state
//   w_data   in   [2*N_SYN] weights, synapse i = {sign,zero} = w_data[2i+1:2i]
//   thr      in   [ACC_W] signed fire threshold, sampled on the final beat
//   clr      in   synchronous abort/clear (weights kept)
//   x_valid  in   input beat valid
//   x_ready  out  block can accept a beat (low while a result is held)
//   x        in   [N_SYN] binary activations
//   x_last   in   final beat of the vector
//   y_valid  out  result valid
//   y_ready  in   downstream accepts the result
//   y_sum    out  [ACC_W] signed saturated sum
//   y_fire   out  y_sum >= thr (signed)
//   y_sat    out  saturation occurred during the vector
// ============================================================================
module ternary_neuron_accum #(
  parameter int N_SYN = 4,
  parameter int ACC_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_load,
  input  logic [2*N_SYN-1:0]   w_data,
  input  logic [ACC_W-1:0]     thr,
  input  logic                 clr,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [N_SYN-1:0]     x,
  input  logic                 x_last,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [ACC_W-1:0]     y_sum,
  output logic                 y_fire,
  output logic                 y_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Clamp limits expressed at the extended ACC_W+1 width.
  localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] ONE     = {{ACC_W{1'b0}}, 1'b1};
  // Every synapse reset to the zero-weight code {sign=0,zero=1}.
  localparam logic [2*N_SYN-1:0]    W_RESET = {N_SYN{2'b01}};

  state_t                  state, state_nxt;
  logic [2*N_SYN-1:0]      weights;
  logic [ACC_W-1:0]        acc;
  logic                    sat;

  logic signed [ACC_W:0]   psum;
  logic signed [ACC_W:0]   s_full;
  logic [ACC_W-1:0]        s;
  logic                    clamp;
  logic                    accept;

  // Partial sum of the ternary products for this beat.
  always_comb begin
    psum = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (x[i] && !weights[2*i]) begin
        if (weights[2*i+1]) begin
          psum = psum - ONE;
        end else begin
          psum = psum + ONE;
        end
      end
    end
  end

  // |psum| <= N_SYN is far below 2^(ACC_W-1), so the sum cannot wrap at
  // ACC_W+1 bits and a plain compare against the limits is exact.
  always_comb begin
    s_full = $signed({acc[ACC_W-1], acc}) + psum;
    clamp  = 1'b0;
    s      = s_full[ACC_W-1:0];
    if (s_full > SUM_MAX) begin
      s     = SUM_MAX[ACC_W-1:0];
      clamp = 1'b1;
    end else if (s_full < SUM_MIN) begin
      s     = SUM_MIN[ACC_W-1:0];
      clamp = 1'b1;
    end
  end

  assign x_ready = (state != HOLD);
  assign y_valid = (state == HOLD);
  assign accept  = x_valid && x_ready && !clr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            state_nxt = x_last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (y_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Weight register: independent of the handshake and of clr, so a beat
  // accepted on the load edge still sees the previous weights.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weights <= W_RESET;
    end else if (w_load) begin
      weights <= w_data;
    end
  end

  // Accumulator and result registers. Result registers are only written on
  // the final beat, which cannot be accepted in HOLD, so they stay stable
  // until the handshake completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      sat    <= 1'b0;
      y_sum  <= '0;
      y_fire <= 1'b0;
      y_sat  <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (accept) begin
      if (x_last) begin
        y_sum  <= s;
        y_fire <= ($signed(s) >= $signed(thr));
        y_sat  <= sat | clamp;
        acc    <= '0;
        sat    <= 1'b0;
      end else begin
        acc <= s;
        sat <= sat | clamp;
      end
    end
  end

endmodule
`default_nettype wire
